// File: rtl/down_counter_timer_pkg.sv
// Shared types and default sizing for the down-counting timer.
package down_counter_timer_pkg;

  localparam int DEF_WIDTH      = 4;
  localparam int DEF_PRESCALE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/down_counter_timer_prescaler.sv
// Clock divider: ticks once every prescale+1 enabled cycles.
import down_counter_timer_pkg::*;

module timer_prescaler #(
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt;

  // Compare against the live setting; a shrunk setting below cnt lets cnt wrap before matching.
  assign tick = en && (cnt == prescale);

  // Divider count: cleared on request, restarts after every tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= tick ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/down_counter_timer.sv
// Programmable down-counting timer with one-shot / auto-reload modes and stop/resume.
import down_counter_timer_pkg::*;

module down_counter_timer #(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  auto_reload,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  tc
);

  state_t           state, state_n;
  logic [WIDTH-1:0] count_n, reload_reg, reload_n;
  logic             tc_n;
  logic             tick;
  logic             pre_clr;

  // The divider only runs in RUN; every entry into RUN therefore starts from zero.
  assign pre_clr = load || stop || (state != RUN);

  timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .clr      (pre_clr),
    .en       (state == RUN),
    .prescale (prescale),
    .tick     (tick)
  );

  // State, count, reload value and terminal pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
      tc         <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      reload_reg <= reload_n;
      tc         <= tc_n;
    end
  end

  assign busy = (state == RUN);

  // Next-state logic; load outranks stop, which outranks start.
  always_comb begin
    state_n  = state;
    count_n  = count;
    reload_n = reload_reg;
    tc_n     = 1'b0;
    if (load) begin
      reload_n = load_val;
      count_n  = load_val;
      state_n  = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start && count != '0) state_n = RUN;
        end
        RUN: begin
          if (stop) begin
            state_n = IDLE;
          end else if (tick) begin
            if (count > WIDTH'(1)) begin
              count_n = count - 1'b1;
            end else if (auto_reload) begin
              count_n = reload_reg;
              tc_n    = 1'b1;
            end else begin
              count_n = '0;
              tc_n    = 1'b1;
              state_n = DONE;
            end
          end
        end
        DONE: begin
          if (start) begin
            count_n = reload_reg;
            state_n = (reload_reg != '0) ? RUN : DONE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench: expected outputs come from closed-form timing of the timer's rules.
module tb_down_counter_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       auto_reload = 1'b0;
  logic [3:0] prescale = '0;
  logic [3:0] count;
  logic       busy;
  logic       tc;

  int n_checks = 0;
  int n_pass   = 0;

  down_counter_timer dut (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
    .stop(stop), .auto_reload(auto_reload), .prescale(prescale),
    .count(count), .busy(busy), .tc(tc)
  );

  always #5 clk = ~clk;

  // Advance one edge; sample and drive 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] v);
    load = 1'b1; load_val = v;
    step();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 start = 1'b1;
    #1;
    n_checks++;
    if (count !== 4'd0 || busy !== 1'b0 || tc !== 1'b0)
      $display("FAIL reset_during: count=%0d busy=%0b tc=%0b want 0/0/0", count, busy, tc);
    else n_pass++;
    #8 start = 1'b0;
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (count !== 4'd0 || busy !== 1'b0 || tc !== 1'b0)
        $display("FAIL reset_after[%0d]: count=%0d busy=%0b tc=%0b want 0/0/0", i, count, busy, tc);
      else n_pass++;
    end
  endtask

  // One-shot: count = N - t/(P+1) until T = N*(P+1), then 0 with tc exactly at T.
  task automatic test_one_shot(input int n, input int p);
    int T;
    logic [3:0] e_count;
    logic e_busy, e_tc;
    T = n * (p + 1);
    prescale = 4'(p); auto_reload = 1'b0;
    do_load(4'(n));
    do_start();
    for (int t = 0; t <= T + 2; t++) begin
      if (t > 0) step();
      e_count = (t < T) ? 4'(n - t / (p + 1)) : 4'd0;
      e_busy  = (t < T);
      e_tc    = (t == T);
      n_checks++;
      if (count !== e_count || busy !== e_busy || tc !== e_tc)
        $display("FAIL one_shot n=%0d p=%0d t=%0d: got %0d/%0b/%0b want %0d/%0b/%0b",
                 n, p, t, count, busy, tc, e_count, e_busy, e_tc);
      else n_pass++;
    end
  endtask

  // Periodic: count cycles N..1, tc every N*(P+1) cycles; then one-shot to DONE and restart.
  task automatic test_periodic(input int n, input int p);
    int T;
    bit seen_done;
    logic [3:0] e_count;
    logic e_tc;
    T = n * (p + 1);
    prescale = 4'(p); auto_reload = 1'b1;
    do_load(4'(n));
    do_start();
    for (int t = 0; t <= 3 * T; t++) begin
      if (t > 0) step();
      e_count = 4'(n - ((t / (p + 1)) % n));
      e_tc    = (t > 0) && (t % T == 0);
      n_checks++;
      if (count !== e_count || busy !== 1'b1 || tc !== e_tc)
        $display("FAIL periodic n=%0d p=%0d t=%0d: got %0d/%0b/%0b want %0d/1/%0b",
                 n, p, t, count, busy, tc, e_count, e_tc);
      else n_pass++;
    end
    auto_reload = 1'b0;
    seen_done = 0;
    for (int i = 0; i < T + 4 && !seen_done; i++) begin
      step();
      if (!busy) seen_done = 1;
    end
    n_checks++;
    if (!seen_done || count !== 4'd0 || tc !== 1'b1)
      $display("FAIL periodic_to_done: done=%0b count=%0d tc=%0b want 1/0/1", seen_done, count, tc);
    else n_pass++;
    do_start();
    n_checks++;
    if (count !== 4'(n) || busy !== 1'b1 || tc !== 1'b0)
      $display("FAIL restart_from_done: count=%0d busy=%0b want %0d/1", count, busy, n);
    else n_pass++;
  endtask

  task automatic test_stop_resume(input int p);
    prescale = 4'(p); auto_reload = 1'b0;
    do_load(4'd9);
    do_start();
    repeat (5 * (p + 1)) step();
    n_checks++;
    if (count !== 4'd4) $display("FAIL stop_reach4: count=%0d want 4", count);
    else n_pass++;
    stop = 1'b1;
    step();
    stop = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (count !== 4'd4 || busy !== 1'b0 || tc !== 1'b0)
        $display("FAIL stop_hold[%0d]: count=%0d busy=%0b want 4/0", i, count, busy);
      else n_pass++;
      step();
    end
    do_start();
    repeat (p) step();
    n_checks++;
    if (count !== 4'd4 || busy !== 1'b1)
      $display("FAIL resume_hold: count=%0d busy=%0b want 4/1", count, busy);
    else n_pass++;
    step();
    n_checks++;
    if (count !== 4'd3 || busy !== 1'b1)
      $display("FAIL resume_dec: count=%0d busy=%0b want 3/1", count, busy);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    load = 1'b1; start = 1'b1; load_val = 4'd6;
    step();
    load = 1'b0; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (count !== 4'd6 || busy !== 1'b0 || tc !== 1'b0)
        $display("FAIL load_start[%0d]: count=%0d busy=%0b want 6/0", i, count, busy);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_zero_start();
    do_load(4'd0);
    do_start();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (count !== 4'd0 || busy !== 1'b0 || tc !== 1'b0)
        $display("FAIL zero_start[%0d]: count=%0d busy=%0b tc=%0b want 0/0/0", i, count, busy, tc);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_abort();
    prescale = 4'd0; auto_reload = 1'b0;
    do_load(4'd5);
    do_start();
    repeat (3) step();
    n_checks++;
    if (count !== 4'd2) $display("FAIL abort_reach2: count=%0d want 2", count);
    else n_pass++;
    do_load(4'd7);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (count !== 4'd7 || busy !== 1'b0 || tc !== 1'b0)
        $display("FAIL abort_load[%0d]: count=%0d busy=%0b tc=%0b want 7/0/0", i, count, busy, tc);
      else n_pass++;
      step();
    end
    do_start();
    repeat (2) step();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (count !== 4'd0 || busy !== 1'b0 || tc !== 1'b0)
      $display("FAIL async_reset: count=%0d busy=%0b tc=%0b want 0/0/0", count, busy, tc);
    else n_pass++;
    step();
    rst = 1'b0;
    step();
    n_checks++;
    if (count !== 4'd0 || busy !== 1'b0 || tc !== 1'b0)
      $display("FAIL post_reset: count=%0d busy=%0b tc=%0b want 0/0/0", count, busy, tc);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_one_shot(5, 0);
    test_periodic(3, 0);
    test_one_shot(4, 2);
    for (int r = 0; r < 4; r++) begin
      test_one_shot(int'($urandom_range(15, 1)), int'($urandom_range(3, 0)));
      test_periodic(int'($urandom_range(6, 1)), int'($urandom_range(2, 0)));
    end
    test_stop_resume(0);
    test_stop_resume(int'($urandom_range(3, 1)));
    test_simultaneous();
    test_zero_start();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/down_counter_timer.md
# down_counter_timer

Programmable down-counting timer, the decrementing counterpart of the 4-bit up-counter in our counter library. Loads a start value, counts down to zero on a prescaled tick and flags terminal count. Supports one-shot or auto-reload (periodic) mode, plus stop/resume. Intended as the timeout/period generator beside the up-counter in the same clock domain.

## Interface
- WIDTH, 4, counter width in bits
- PRESCALE_W, 4, width of the prescale divider setting
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- load  input  1  single-cycle strobe: capture load_val into reload register and count
- load_val  input  WIDTH  value captured on load
- start  input  1  single-cycle strobe: begin or resume counting
- stop  input  1  single-cycle strobe: pause counting, hold count
- auto_reload  input  1  level: 1 = periodic, 0 = one-shot; sampled at each terminal tick
- prescale  input  PRESCALE_W  decrement every prescale+1 clk cycles; sampled continuously
- count  output  WIDTH  current count value (registered)
- busy  output  1  high while in RUN
- tc  output  1  terminal-count pulse, one clk cycle wide (registered)

## Operation
- States: IDLE, RUN, DONE.
- Reset: count=0, busy=0, tc=0, reload register=0, prescaler=0, state IDLE. Reset applies immediately, including mid-run.
- Priority on the same edge: load > stop > start.
- load, any state: reload_reg<=load_val, count<=load_val, prescaler<=0, state IDLE. A load during RUN aborts the run; no tc.
- start in IDLE: if count!=0, go to RUN with prescaler<=0; if count==0, ignored.
- start in DONE: count<=reload_reg, prescaler<=0, go to RUN if reload_reg!=0, else stay DONE.
- start in RUN: ignored, no prescaler restart.
- stop in RUN: go to IDLE, count held, prescaler<=0. A later start resumes from the held count. stop in IDLE or DONE is ignored.
- RUN: prescaler increments each cycle. When prescaler==prescale, a tick occurs and prescaler<=0.
  - Tick with count>1: count<=count-1.
  - Tick with count==1 and auto_reload=1: count<=reload_reg, tc<=1, stay RUN.
  - Tick with count==1 and auto_reload=0: count<=0, tc<=1, go to DONE.
- Count never wraps below 0; decrementing from 0 is impossible by construction.
- tc is 0 in every cycle without a terminal tick. busy = (state==RUN).
- If prescale changes mid-run and the prescaler already exceeds the new value, the prescaler counts on to its maximum, wraps to 0, then matches.

## Timing
- start sampled at edge k puts busy=1 after edge k. The first decrement happens at edge k+prescale+1.
- Consecutive decrements are spaced prescale+1 cycles apart.
- One-shot from load value N: tc is high in the same cycle count first reads 0, N*(prescale+1) cycles after the start edge. busy drops on that same edge.
- Auto-reload period: tc pulses every N*(prescale+1) cycles. count cycles through N..1 and never shows 0.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package down_counter_timer_pkg holds:
  - the state enum type (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - default parameter constants.
- Sub-module timer_prescaler holds:
  - a PRESCALE_W counter with clr input and tick output;
  - tick asserted when the count equals prescale and enable is high.
- The top level holds the FSM, the count register and the reload register.

## Test plan
- Reset behaviour: assert rst for 12 ns, with a start strobe during reset. Required: count=0, busy=0, tc=0 throughout and after release; the strobe has no effect.
- One-shot: load 5, prescale=0, auto_reload=0, start. Required: count reads 5,4,3,2,1,0 on successive edges; tc high only in the cycle with count 0; busy falls on that same edge; count then stays 0.
- Periodic and restart from DONE:
  - load 3, prescale=0, auto_reload=1, start. Required: count sequence 3,2,1,3,2,1…; tc pulses every 3 cycles; busy stays high.
  - Then clear auto_reload, let the run reach DONE, and issue start. Required: the count restarts at 3.
- Prescale: load 4, prescale=2, start. Required: each value is held 3 cycles; tc arrives 12 cycles after the start edge.
- Stop/resume, simultaneous strobes, zero count:
  - stop at count 4 of a load-9 run. Required: count holds 4 and busy=0 for 10 cycles; start resumes 4→3 after prescale+1 cycles.
  - Assert load and start together. Required: load wins and state is IDLE.
  - Issue start with count 0. Required: it is ignored.
- Abort: load 7 mid-run at count 2. Required: count=7, busy=0, no tc. Assert rst mid-run. Required: all outputs 0 immediately.
